// File: rtl/dvv_res_hw_pkg.sv
// Shared types for the resource-table arbiter: operation codes and controller states.
package dvv_res_hw_pkg;

    typedef enum logic [1:0] {
        OP_GET = 2'b00,
        OP_SET = 2'b01,
        OP_DEL = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // The reserved encoding 2'b11 behaves exactly like a GET.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return OP_SET;
            2'b10:   return OP_DEL;
            default: return OP_GET;
        endcase
    endfunction

endpackage

// File: rtl/dvv_rr_arb.sv
// Round-robin arbiter: priority starts just after the last granted requester.
module dvv_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int IW = $clog2(N);

    // Scan requesters from last+1 around the ring and pick the first one asking.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!grant_any && req[(int'(last) + off) % N]) begin
                grant_any                      = 1'b1;
                grant_idx                      = IW'((int'(last) + off) % N);
                grant[(int'(last) + off) % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dvv_res_arb.sv
// Shared key/value resource table with round-robin access from several requesters.
// One transaction at a time: accept, linear search of the table, one-cycle response.
module dvv_res_arb
    import dvv_res_hw_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DEPTH  = 8,
    parameter int KEY_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [KEY_W*N_REQ-1:0]     req_key,
    input  logic [DATA_W*N_REQ-1:0]    req_data,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       rsp_hit,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [$clog2(DEPTH):0]     used,
    output logic                       full
);

    localparam int IW = $clog2(N_REQ);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    state_e              state;
    state_e              next_state;

    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       cur_id;
    op_e                 cur_op;
    logic [KEY_W-1:0]    cur_key;
    logic [DATA_W-1:0]   cur_data;

    logic [AW-1:0]       scan_idx;
    logic                match_found;
    logic [AW-1:0]       match_idx;
    logic                free_found;
    logic [AW-1:0]       free_idx;

    logic [DEPTH-1:0]    ent_valid;
    logic [KEY_W-1:0]    ent_key [DEPTH];
    logic [DATA_W-1:0]   ent_val [DEPTH];
    logic [UW-1:0]       used_cnt;

    logic [N_REQ-1:0]    arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;

    logic                accept;
    logic                scan_hit;
    logic                scan_last;

    dvv_rr_arb #(
        .N (N_REQ)
    ) u_rr_arb (
        .req       (req_valid),
        .last      (last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign accept    = (state == ST_IDLE) && arb_any;
    assign scan_hit  = ent_valid[scan_idx] && (ent_key[scan_idx] == cur_key);
    assign scan_last = (scan_idx == AW'(DEPTH - 1));
    assign used      = used_cnt;
    assign full      = (used_cnt == UW'(DEPTH));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: grant in IDLE, stop searching on match or after the last entry.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (arb_any) next_state = ST_SEARCH;
            ST_SEARCH: if (scan_hit || scan_last) next_state = ST_RESP;
            ST_RESP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs: accept strobe in IDLE, response fields only during RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_hit   = 1'b0;
        rsp_data  = '0;
        if (state == ST_IDLE && !rst) begin
            req_ready = arb_grant;
        end
        if (state == ST_RESP) begin
            rsp_valid = 1'b1;
            rsp_id    = cur_id;
            if (cur_op == OP_SET) begin
                rsp_hit = match_found || free_found;
            end else begin
                rsp_hit = match_found;
            end
            if (cur_op == OP_GET && match_found) begin
                rsp_data = ent_val[match_idx];
            end
        end
    end

    // Transaction capture at accept and search bookkeeping (match and first free slot).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= IW'(N_REQ - 1);
            cur_id      <= '0;
            cur_op      <= OP_GET;
            cur_key     <= '0;
            cur_data    <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
        end else if (accept) begin
            last_grant  <= arb_idx;
            cur_id      <= arb_idx;
            cur_op      <= decode_op(req_op[2*arb_idx +: 2]);
            cur_key     <= req_key[KEY_W*arb_idx +: KEY_W];
            cur_data    <= req_data[DATA_W*arb_idx +: DATA_W];
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
        end else if (state == ST_SEARCH) begin
            if (scan_hit) begin
                match_found <= 1'b1;
                match_idx   <= scan_idx;
            end else if (!ent_valid[scan_idx] && !free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
            scan_idx <= scan_idx + 1'b1;
        end
    end

    // Valid bits and occupancy count change only at the end of RESP, with guarded counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            used_cnt  <= '0;
        end else if (state == ST_RESP) begin
            if (cur_op == OP_SET && !match_found && free_found && used_cnt != UW'(DEPTH)) begin
                ent_valid[free_idx] <= 1'b1;
                used_cnt            <= used_cnt + 1'b1;
            end else if (cur_op == OP_DEL && match_found && used_cnt != '0) begin
                ent_valid[match_idx] <= 1'b0;
                used_cnt             <= used_cnt - 1'b1;
            end
        end
    end

    // Key/value storage; contents of invalid entries are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && cur_op == OP_SET) begin
            if (match_found) begin
                ent_val[match_idx] <= cur_data;
            end else if (free_found) begin
                ent_key[free_idx] <= cur_key;
                ent_val[free_idx] <= cur_data;
            end
        end
    end

endmodule

// File: tb/tb_dvv_res_arb.sv
// Self-checking bench for dvv_res_arb: directed vector table, multi-cycle corner
// sequences (round-robin, reset abort) and random traffic against a table model.
module tb_dvv_res_arb;

    localparam int N_REQ  = 4;
    localparam int DEPTH  = 8;
    localparam int KEY_W  = 8;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ-1:0]         req_ready;
    logic [2*N_REQ-1:0]       req_op = '0;
    logic [KEY_W*N_REQ-1:0]   req_key = '0;
    logic [DATA_W*N_REQ-1:0]  req_data = '0;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic                     rsp_hit;
    logic [DATA_W-1:0]        rsp_data;
    logic [3:0]               used;
    logic                     full;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table: a plain array of slots.
    logic              mv [DEPTH];
    logic [KEY_W-1:0]  mk [DEPTH];
    logic [DATA_W-1:0] md [DEPTH];

    typedef struct {
        int              id;
        logic [1:0]      op;
        logic [7:0]      key;
        logic [31:0]     data;
        logic            exp_hit;
        logic [31:0]     exp_data;
        int              exp_lat;
        int              exp_used;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dvv_res_arb #(
        .N_REQ  (N_REQ),
        .DEPTH  (DEPTH),
        .KEY_W  (KEY_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_key   (req_key),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_hit   (rsp_hit),
        .rsp_data  (rsp_data),
        .used      (used),
        .full      (full)
    );

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int model_used();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (mv[i]) c++;
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    endfunction

    // Apply one operation to the reference table; latency follows the linear search rule.
    function automatic void model_txn(input logic [1:0] op, input logic [KEY_W-1:0] key,
                                      input logic [DATA_W-1:0] data, output logic hit,
                                      output logic [DATA_W-1:0] rdata, output int lat);
        int m = -1;
        int f = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m < 0 && mv[i] && mk[i] == key) m = i;
            if (f < 0 && !mv[i]) f = i;
        end
        hit   = 1'b0;
        rdata = '0;
        lat   = (m >= 0) ? m + 2 : DEPTH + 1;
        case (op)
            2'b01: begin
                if (m >= 0) begin
                    md[m] = data;
                    hit   = 1'b1;
                end else if (f >= 0) begin
                    mv[f] = 1'b1;
                    mk[f] = key;
                    md[f] = data;
                    hit   = 1'b1;
                end
            end
            2'b10: begin
                if (m >= 0) begin
                    mv[m] = 1'b0;
                    hit   = 1'b1;
                end
            end
            default: begin
                if (m >= 0) begin
                    hit   = 1'b1;
                    rdata = md[m];
                end
            end
        endcase
    endfunction

    // Drive one request from requester id, wait for accept and response (both bounded).
    task automatic applyStimulus(input int id, input logic [1:0] op, input logic [KEY_W-1:0] key,
                                 input logic [DATA_W-1:0] data, output int rdy_wait, output int lat,
                                 output logic hit, output logic [DATA_W-1:0] rdata, output logic [1:0] rid);
        req_op[2*id +: 2]              = op;
        req_key[KEY_W*id +: KEY_W]     = key;
        req_data[DATA_W*id +: DATA_W]  = data;
        req_valid[id]                  = 1'b1;
        rdy_wait = 0;
        lat      = 0;
        hit      = 1'b0;
        rdata    = '0;
        rid      = '0;
        #1;
        while (!req_ready[id] && rdy_wait < 50) begin
            @(posedge clk); #1;
            rdy_wait++;
        end
        if (!req_ready[id]) begin
            checkOutput("ready_timeout", 64'd1, 64'd0);
            req_valid[id] = 1'b0;
            return;
        end
        checkOutput("ready_onehot", 64'(req_ready), 64'(4'b0001 << id));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 64'd1, 64'd0);
            return;
        end
        hit   = rsp_hit;
        rdata = rsp_data;
        rid   = rsp_id;
        @(posedge clk); #1;
    endtask

    // Reset with every requester asking, so ready must stay low while reset is held.
    task automatic doReset();
        rst       = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("rst_rsp_hit", 64'(rsp_hit), 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("rst_used", 64'(used), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        req_valid = '0;
        rst       = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        int          rw, lat, mlat, seen, cyc, g;
        logic        hit, mhit;
        logic [31:0] rdata, mdata;
        logic [1:0]  rid;
        int          gq[$];
        int          rq[$];
        int          exp_order[5];

        // Directed vectors: GET/SET/DEL basics, overwrite, double delete, fill, full, reuse.
        vecs.push_back('{0, 2'b00, 8'h11, 32'h0,        1'b0, 32'h0,        9, 0});
        vecs.push_back('{1, 2'b01, 8'h11, 32'hCAFE0001, 1'b1, 32'h0,        9, 1});
        vecs.push_back('{2, 2'b00, 8'h11, 32'h0,        1'b1, 32'hCAFE0001, 2, 1});
        vecs.push_back('{3, 2'b01, 8'h11, 32'h2,        1'b1, 32'h0,        2, 1});
        vecs.push_back('{0, 2'b00, 8'h11, 32'h0,        1'b1, 32'h2,        2, 1});
        vecs.push_back('{1, 2'b10, 8'h11, 32'h0,        1'b1, 32'h0,        2, 0});
        vecs.push_back('{2, 2'b10, 8'h11, 32'h0,        1'b0, 32'h0,        9, 0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{i % 4, 2'b01, 8'(8'h20 + i), 32'(32'h1000 + i), 1'b1, 32'h0, 9, i + 1});
        vecs.push_back('{3, 2'b01, 8'h99, 32'hDEAD,     1'b0, 32'h0,        9, 8});
        vecs.push_back('{0, 2'b10, 8'h23, 32'h0,        1'b1, 32'h0,        5, 7});
        vecs.push_back('{1, 2'b01, 8'h99, 32'h99,       1'b1, 32'h0,        9, 8});
        vecs.push_back('{2, 2'b00, 8'h99, 32'h0,        1'b1, 32'h99,       5, 8});
        vecs.push_back('{3, 2'b11, 8'h20, 32'h0,        1'b1, 32'h1000,     2, 8});
        vecs.push_back('{0, 2'b00, 8'h27, 32'h0,        1'b1, 32'h1007,     9, 8});

        doReset();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].id, vecs[i].op, vecs[i].key, vecs[i].data, rw, lat, hit, rdata, rid);
            model_txn(vecs[i].op, vecs[i].key, vecs[i].data, mhit, mdata, mlat);
            checkOutput($sformatf("v%0d_ready_wait", i), 64'(rw), 64'd0);
            checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_id", i), 64'(rid), 64'(vecs[i].id));
            checkOutput($sformatf("v%0d_hit", i), 64'(hit), 64'(vecs[i].exp_hit));
            checkOutput($sformatf("v%0d_data", i), 64'(rdata), 64'(vecs[i].exp_data));
            checkOutput($sformatf("v%0d_used", i), 64'(used), 64'(vecs[i].exp_used));
            checkOutput($sformatf("v%0d_full", i), 64'(full), 64'(vecs[i].exp_used == DEPTH));
        end

        // Round-robin: all requesters hold GET requests continuously.
        doReset();
        for (int i = 0; i < N_REQ; i++) begin
            req_op[2*i +: 2]         = 2'b00;
            req_key[KEY_W*i +: KEY_W] = 8'(8'h40 + i);
        end
        req_valid = '1;
        #1;
        cyc = 0;
        while (rq.size() < 5 && cyc < 300) begin
            if (req_ready != '0) begin
                checkOutput("rr_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                g = 0;
                for (int b = 0; b < N_REQ; b++) if (req_ready[b]) g = b;
                gq.push_back(g);
            end
            if (rsp_valid) begin
                rq.push_back(int'(rsp_id));
                if (rq.size() == 5) req_valid = '0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_grant%0d", i), 64'((gq.size() > i) ? gq[i] : 15), 64'(exp_order[i]));
            checkOutput($sformatf("rr_rsp_id%0d", i), 64'((rq.size() > i) ? rq[i] : 15), 64'(exp_order[i]));
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset during the search of a SET: no response, no table update.
        doReset();
        req_op[2*1 +: 2]          = 2'b01;
        req_key[KEY_W*1 +: KEY_W] = 8'h55;
        req_data[DATA_W*1 +: DATA_W] = 32'h5555;
        req_valid[1] = 1'b1;
        #1;
        checkOutput("abort_ready", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checkOutput("abort_no_rsp", 64'(seen), 64'd0);
        checkOutput("abort_used", 64'(used), 64'd0);
        model_reset();
        applyStimulus(2, 2'b00, 8'h55, 32'h0, rw, lat, hit, rdata, rid);
        checkOutput("abort_get_hit", 64'(hit), 64'd0);
        checkOutput("abort_get_lat", 64'(lat), 64'(DEPTH + 1));

        // Random traffic against the reference table; 11 keys over 8 slots exercises full.
        doReset();
        for (int t = 0; t < 60; t++) begin
            int          id;
            int          r;
            logic [1:0]  op;
            logic [7:0]  key;
            logic [31:0] data;
            id   = $urandom_range(0, N_REQ - 1);
            r    = $urandom_range(0, 9);
            op   = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r == 7) ? 2'b11 : 2'b00;
            key  = 8'(8'h30 + $urandom_range(0, 10));
            data = $urandom;
            applyStimulus(id, op, key, data, rw, lat, hit, rdata, rid);
            model_txn(op, key, data, mhit, mdata, mlat);
            checkOutput($sformatf("r%0d_latency", t), 64'(lat), 64'(mlat));
            checkOutput($sformatf("r%0d_id", t), 64'(rid), 64'(id));
            checkOutput($sformatf("r%0d_hit", t), 64'(hit), 64'(mhit));
            checkOutput($sformatf("r%0d_data", t), 64'(rdata), 64'(mdata));
            checkOutput($sformatf("r%0d_used", t), 64'(used), 64'(model_used()));
            checkOutput($sformatf("r%0d_full", t), 64'(full), 64'(model_used() == DEPTH));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvv_res_arb.md
DVV_RES_ARB -- requirements
Module: dvv_res_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the resource table (2..8).
REQ-002 Parameter DEPTH, default 8: number of key/value entries in the table (power of 2).
REQ-003 Parameter KEY_W, default 8: key width.
REQ-004 Parameter DATA_W, default 32: value width.
REQ-005 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-high.
REQ-007 Port req_valid  in  N_REQ  per-requester request valid.
REQ-008 Port req_ready  out  N_REQ  per-requester accept; at most one bit high.
REQ-009 Port req_op  in  2*N_REQ  per-requester op: 00 GET, 01 SET, 10 DEL, 11 reserved (treated as GET).
REQ-010 Port req_key  in  KEY_W*N_REQ  per-requester key, requester i at slice i.
REQ-011 Port req_data  in  DATA_W*N_REQ  per-requester SET value.
REQ-012 Port rsp_valid  out  1  one-cycle response strobe, no backpressure.
REQ-013 Port rsp_id  out  $clog2(N_REQ)  index of requester being answered.
REQ-014 Port rsp_hit  out  1  GET/DEL: key found; SET: write performed.
REQ-015 Port rsp_data  out  DATA_W  GET value on hit, else 0.
REQ-016 Port used  out  $clog2(DEPTH)+1  count of valid entries.
REQ-017 Port full  out  1  high when used == DEPTH.

Function
REQ-018 FSM states IDLE, SEARCH, RESP; one transaction in flight at a time.
REQ-019 IDLE: if any req_valid, round-robin grant; req_ready[g] high combinationally for one cycle, next state SEARCH; op/key/data latched at accept.
REQ-020 Round-robin priority starts at (last granted + 1) mod N_REQ; last-granted updates only on accept.
REQ-021 Requester holds req_valid and fields stable until req_ready; dropping valid before accept is legal, no side effect.
REQ-022 SEARCH examines entry k in cycle T+1+k after accept cycle T; also records lowest-index invalid entry as free slot.
REQ-023 Match (entry valid and key equal) ends SEARCH immediately; no match ends after entry DEPTH-1.
REQ-024 RESP lasts one cycle: rsp_valid=1, table update applied at end of this cycle, next state IDLE (no grant in RESP).
REQ-025 Latency accept-to-rsp_valid: k+2 cycles on match at entry k; DEPTH+1 cycles on miss.
REQ-026 GET: hit returns stored value; miss rsp_hit=0, rsp_data=0.
REQ-027 SET: hit overwrites value; miss writes to free slot, sets valid, used+1; miss with table full: no write, rsp_hit=0.
REQ-028 DEL: hit clears valid, used-1; miss: no change, rsp_hit=0.
REQ-029 rsp_data=0 for SET and DEL; rsp_id/rsp_hit/rsp_data=0 whenever rsp_valid=0.
REQ-030 used never wraps: saturates at DEPTH and 0 by construction (guarded updates).

Reset
REQ-031 rst asserted: state IDLE, all entries invalid, used=0, full=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_data=0, last-granted = N_REQ-1 (requester 0 first).
REQ-032 rst mid-transaction aborts it: no response issued, no table update; entry values need not be cleared.

Structure
REQ-033 Shared package dvv_res_hw_pkg holds op enum (GET/SET/DEL) and FSM state enum.
REQ-034 Round-robin grant logic is a sub-module dvv_rr_arb (request vector, last-grant, one-hot grant out).

Verification
REQ-035 After reset, req0 GET key 0x11 -> ready at cycle 0, rsp_valid at cycle DEPTH+1=9, id0 hit0 data0.
REQ-036 req1 SET 0x11=0xCAFE0001, then req2 GET 0x11 -> SET hit1 used=1; GET rsp at accept+2, id2 hit1 data 0xCAFE0001.
REQ-037 All four requesters valid continuously with GET -> grants in order 0,1,2,3,0; each gets exactly one rsp with matching rsp_id.
REQ-038 Fill 8 distinct keys, 9th SET key 0x99 -> hit0, full=1, used=8; DEL key of entry 3 then SET 0x99 -> written to entry 3, hit1, full=1.
REQ-039 SET existing key 0x11=0x2 -> used unchanged, later GET returns 0x2; DEL 0x11 twice -> hit1 then hit0, used decrements once.
REQ-040 rst pulsed during SEARCH of a SET -> no rsp_valid, used=0 and GET of that key misses afterwards.
